// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared integer register file widths and types
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int ADDR      = 5;
    localparam int REG_COUNT = 2 ** ADDR;

    typedef logic [ADDR-1:0] reg_addr_t;
    typedef logic [XLEN-1:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits, popcount and hazard lookups
// Optional write-through busy masking under REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int ADDR = riscv_pkg::ADDR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            write_en,
    input  logic [ADDR-1:0] rd_addr,
    input  logic            issue_en,
    input  logic [ADDR-1:0] issue_rd,
    input  logic [ADDR-1:0] rs1_addr,
    input  logic [ADDR-1:0] rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [ADDR:0]   busy_count
);

    localparam int NREGS = 2 ** ADDR;

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [ADDR:0]    count_next;

    // Clear first, then set, so a new producer supersedes the retiring one.
    always_comb begin
        busy_next = busy;
        if (write_en && rd_addr != '0) begin
            busy_next[rd_addr] = 1'b0;
        end
        if (issue_en && issue_rd != '0) begin
            busy_next[issue_rd] = 1'b1;
        end
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            count_next = count_next + {{ADDR{1'b0}}, busy_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // A retiring write to the looked-up register resolves the hazard now,
    // unless a new producer is issuing to it in the same cycle.
    always_comb begin
        rs1_busy = busy[rs1_addr];
        rs2_busy = busy[rs2_addr];
        if (write_en && rd_addr == rs1_addr && rs1_addr != '0
            && !(issue_en && issue_rd == rs1_addr)) begin
            rs1_busy = 1'b0;
        end
        if (write_en && rd_addr == rs2_addr && rs2_addr != '0
            && !(issue_en && issue_rd == rs2_addr)) begin
            rs2_busy = 1'b0;
        end
    end
`else
    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];
`endif

endmodule

// File: rtl/register_file_core.sv
// rtl/register_file_core.sv - 32 x XLEN register file with busy scoreboard
// Optional same-cycle write-through bypass under REGFILE_BYPASS_EN.
module register_file_core #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int ADDR = riscv_pkg::ADDR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ADDR-1:0] rs1_addr,
    input  logic [ADDR-1:0] rs2_addr,
    output logic [XLEN-1:0] data_out_rs1,
    output logic [XLEN-1:0] data_out_rs2,
    input  logic            write_en,
    input  logic [ADDR-1:0] rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic            issue_en,
    input  logic [ADDR-1:0] issue_rd,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [ADDR:0]   busy_count
);

    import riscv_pkg::*;

    localparam int NREGS = 2 ** ADDR;

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en && rd_addr != '0) begin
            regs[rd_addr] <= rd_data;
        end
    end

    always_comb begin
        data_out_rs1 = (rs1_addr == '0) ? '0 : regs[rs1_addr];
        data_out_rs2 = (rs2_addr == '0) ? '0 : regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (write_en && rd_addr == rs1_addr && rs1_addr != '0) begin
            data_out_rs1 = rd_data;
        end
        if (write_en && rd_addr == rs2_addr && rs2_addr != '0) begin
            data_out_rs2 = rd_data;
        end
`endif
    end

    regfile_scoreboard #(
        .ADDR(ADDR)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .rd_addr    (rd_addr),
        .issue_en   (issue_en),
        .issue_rd   (issue_rd),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .busy_count (busy_count)
    );

endmodule

// File: tb/tb_register_file_core.sv
// tb/tb_register_file_core.sv - directed self-checking bench for register_file_core
module tb_register_file_core;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] data_out_rs1;
    logic [31:0] data_out_rs2;
    logic        write_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [5:0]  busy_count;

    int compared;
    int mismatched;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    register_file_core dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .data_out_rs1 (data_out_rs1),
        .data_out_rs2 (data_out_rs2),
        .write_en     (write_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .issue_en     (issue_en),
        .issue_rd     (issue_rd),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .busy_count   (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_en = 1'b0;
        issue_en = 1'b0;
        rd_addr  = '0;
        rd_data  = '0;
        issue_rd = '0;
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); rs1_addr = '0; rs2_addr = '0;
        step();
        rst = 1'b0;
        write_en = 1'b1; rd_addr = 5'd10; rd_data = 32'hFFFF_0000;
        issue_en = 1'b1; issue_rd = 5'd11;
        step();
        idle(); rs1_addr = 5'd10; rs2_addr = 5'd11;
        #1;
        compared++;
        if (data_out_rs1 !== 32'hFFFF_0000 || rs2_busy !== 1'b1 || busy_count !== 6'd1) begin
            mismatched++;
            $display("FAIL pre_reset: rs1=%h busy2=%b cnt=%0d expected ffff0000 1 1",
                     data_out_rs1, rs2_busy, busy_count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk32("reset_rs1_data", data_out_rs1, 32'h0);
        chk32("reset_rs2_data", data_out_rs2, 32'h0);
        chk32("reset_rs1_busy", {31'd0, rs1_busy}, 32'h0);
        chk32("reset_rs2_busy", {31'd0, rs2_busy}, 32'h0);
        chk32("reset_busy_count", {26'd0, busy_count}, 32'h0);
    endtask

    task automatic test_x0_write();
        write_en = 1'b1; rd_addr = 5'd0; rd_data = 32'hDEAD_BEEF;
        issue_en = 1'b1; issue_rd = 5'd0;
        rs1_addr = 5'd0;
        #1;
        chk32("x0_same_cycle", data_out_rs1, 32'h0);
        step();
        idle();
        #1;
        chk32("x0_read", data_out_rs1, 32'h0);
        chk32("x0_busy", {31'd0, rs1_busy}, 32'h0);
        chk32("x0_busy_count", {26'd0, busy_count}, 32'h0);
    endtask

    task automatic test_write_read();
        write_en = 1'b1; rd_addr = 5'd5; rd_data = 32'h1234_5678;
        step();
        idle(); rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        chk32("x5_rs1", data_out_rs1, 32'h1234_5678);
        chk32("x5_rs2", data_out_rs2, 32'h1234_5678);
        chk32("x5_nonbusy_write_count", {26'd0, busy_count}, 32'h0);
    endtask

    task automatic test_same_cycle();
        write_en = 1'b1; rd_addr = 5'd7; rd_data = 32'h0000_1111;
        step();
        rs1_addr = 5'd7; rs2_addr = 5'd5;
        write_en = 1'b1; rd_addr = 5'd7; rd_data = 32'hCAFE_0001;
        #1;
        chk32("x7_write_cycle", data_out_rs1, BYP ? 32'hCAFE_0001 : 32'h0000_1111);
        chk32("x5_unaffected", data_out_rs2, 32'h1234_5678);
        step();
        idle();
        #1;
        chk32("x7_next_cycle", data_out_rs1, 32'hCAFE_0001);
    endtask

    task automatic test_scoreboard();
        issue_en = 1'b1; issue_rd = 5'd3;
        step();
        chk32("count_after_x3", {26'd0, busy_count}, 32'd1);
        issue_rd = 5'd4;
        step();
        chk32("count_after_x4", {26'd0, busy_count}, 32'd2);
        issue_rd = 5'd3;
        step();
        chk32("count_after_x3_again", {26'd0, busy_count}, 32'd2);
        idle(); rs1_addr = 5'd3; rs2_addr = 5'd4;
        #1;
        chk32("x3_busy", {31'd0, rs1_busy}, 32'd1);
        write_en = 1'b1; rd_addr = 5'd3; rd_data = 32'h0000_0033;
        #1;
        chk32("x3_busy_write_cycle", {31'd0, rs1_busy}, BYP ? 32'd0 : 32'd1);
        step();
        idle();
        #1;
        chk32("count_after_wb_x3", {26'd0, busy_count}, 32'd1);
        chk32("x3_busy_after_wb", {31'd0, rs1_busy}, 32'd0);
        chk32("x4_still_busy", {31'd0, rs2_busy}, 32'd1);
    endtask

    task automatic test_back_to_back();
        issue_en = 1'b1; issue_rd = 5'd9;
        step();
        chk32("count_x9_issue", {26'd0, busy_count}, 32'd2);
        issue_en = 1'b1; issue_rd = 5'd9;
        write_en = 1'b1; rd_addr = 5'd9; rd_data = 32'h0000_00AA;
        rs1_addr = 5'd9;
        #1;
        chk32("x9_busy_set_wins_cycle", {31'd0, rs1_busy}, 32'd1);
        step();
        idle();
        #1;
        chk32("x9_busy_after", {31'd0, rs1_busy}, 32'd1);
        chk32("x9_data", data_out_rs1, 32'h0000_00AA);
        chk32("count_set_wins", {26'd0, busy_count}, 32'd2);
        rst = 1'b1;
        write_en = 1'b1; rd_addr = 5'd12; rd_data = 32'h0000_0055;
        issue_en = 1'b1; issue_rd = 5'd12;
        step();
        rst = 1'b0; idle();
        rs1_addr = 5'd12; rs2_addr = 5'd9;
        #1;
        chk32("rst_blocks_write", data_out_rs1, 32'h0);
        chk32("rst_blocks_issue", {31'd0, rs1_busy}, 32'd0);
        chk32("rst_clears_x9_busy", {31'd0, rs2_busy}, 32'd0);
        chk32("rst_clears_x9_data", data_out_rs2, 32'h0);
        chk32("rst_count", {26'd0, busy_count}, 32'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        rs1_addr = '0;
        rs2_addr = '0;
        idle();
        test_reset();
        test_x0_write();
        test_write_read();
        test_same_cycle();
        test_scoreboard();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/register_file_core.md
Name: register_file_core

Overview:
- Responder end of the register file interface: storage serving the decode read ports and the writeback write port.
- 32 x XLEN integer register file:
  - two asynchronous read ports for decode;
  - one synchronous write port from writeback;
  - x0 hardwired to zero.
- Includes a per-register busy scoreboard, set at issue and cleared at writeback, so decode can detect RAW hazards and stall.

Parameters:
- XLEN, 32, register data width.
- ADDR, 5, register address width; register count = 2**ADDR.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rs1_addr  input  ADDR  read port 1 address (decode).
- rs2_addr  input  ADDR  read port 2 address (decode).
- data_out_rs1  output  XLEN  read port 1 data, combinational.
- data_out_rs2  output  XLEN  read port 2 data, combinational.
- write_en  input  1  writeback write strobe.
- rd_addr  input  ADDR  writeback destination.
- rd_data  input  XLEN  writeback data.
- issue_en  input  1  decode issues an instruction that writes issue_rd.
- issue_rd  input  ADDR  destination of issuing instruction.
- rs1_busy  output  1  rs1_addr has an outstanding producer.
- rs2_busy  output  1  rs2_addr has an outstanding producer.
- busy_count  output  ADDR+1  number of registers currently busy.

Behaviour:
- Reset (rst=1 at clk edge):
  - all registers cleared to 0;
  - all busy bits cleared;
  - busy_count = 0.
  - Reset overrides write_en and issue_en in the same cycle.
  - Outputs settle combinationally from cleared state; there is no reset-time output register.
- Read:
  - data_out_rsN = regs[rsN_addr], combinational, zero latency.
  - Address 0 always returns 0.
- Write:
  - On clk edge, if write_en and rd_addr != 0, then regs[rd_addr] <= rd_data.
  - Writes to x0 are discarded.
- Scoreboard, per register r != 0, evaluated at clk edge:
  - set when issue_en and issue_rd == r;
  - clear when write_en and rd_addr == r;
  - set and clear on the same r in the same cycle: set wins (a new producer supersedes the retiring one); data is still written.
  - issue_rd == 0 and rd_addr == 0 never affect any busy bit; busy[0] is constant 0.
  - A write to a register that is not busy is legal: data is written, busy is unchanged.
  - A second issue to an already-busy register keeps it busy. There is no per-register counter; the in-order pipeline guarantees at most one outstanding producer per register.
- rsN_busy = busy[rsN_addr], masked as described under Optional Feature.
- busy_count:
  - registered population count of busy bits, updated the same edge as the bits;
  - range 0..31, cannot overflow ADDR+1 bits.
- Simultaneous read and write to the same address: controlled by Optional Feature.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - write-through bypass: if write_en and rd_addr == rsN_addr != 0, data_out_rsN = rd_data in the same cycle;
  - rsN_busy is forced 0 in that cycle, unless issue_en targets the same register, in which case busy stays asserted per the set-wins rule.
- Undefined:
  - data_out_rsN returns the pre-write value during the write cycle; the new value is visible the next cycle;
  - rsN_busy reflects the stored busy bit only.
  - Decode must stall one extra cycle.

Decomposition:
- Shared package riscv_pkg:
  - XLEN, ADDR;
  - REG_COUNT = 2**ADDR;
  - typedef reg_addr_t = logic [ADDR-1:0];
  - typedef xlen_t = logic [XLEN-1:0].
- Sub-module regfile_scoreboard:
  - holds the busy vector, set/clear logic, popcount register and busy lookups;
  - register_file_core instantiates it alongside the storage array and bypass muxes.

Test Plan:
- Assert rst with prior nonzero contents, release -> every rsN read returns 0, rs1_busy = rs2_busy = 0, busy_count = 0.
- write_en=1, rd_addr=0, rd_data=32'hDEADBEEF; then read rs1_addr=0 -> data_out_rs1 = 0, busy_count unchanged.
- Write x5=32'h1234_5678; next cycle rs1_addr=5, rs2_addr=5 -> both ports 32'h1234_5678.
- Same cycle: write_en to x7 = 32'hCAFE_0001 with rs1_addr=7:
  - bypass defined -> data_out_rs1 = 32'hCAFE_0001 that cycle;
  - undefined -> old value that cycle, 32'hCAFE_0001 next cycle.
- issue_en to x3, x4, x3 on three cycles -> busy_count 1, 2, 2, rs1_busy(x3)=1; then write x3 -> busy_count 1, rs1_busy(x3)=0.
- Same edge: issue_en to x9 and write_en to x9 = 32'h0000_00AA while x9 busy -> x9 stays busy, regs[9] = 32'hAA; rst asserted in a cycle with write_en and issue_en -> no write, all busy bits cleared.
